// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg -- shared types and constants for the scan_mux block.
//   state_e      : auto-scan controller states
//   MODE_MANUAL  : mode input value selecting the manual select path
//   MODE_AUTO    : mode input value selecting the auto-scan path
package scan_mux_pkg;

  typedef enum logic [1:0] {
    MANUAL     = 2'd0,
    AUTO_DWELL = 2'd1,
    AUTO_HOLD  = 2'd2
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

endpackage

// File: rtl/scan_mux_mux_slice.sv
// mux_slice -- one combinational 2**SEL_W : 1 mux of W-bit inputs with an
// active-low strobe that forces the output to zero.
// Ports:
//   i_d   in  (2**SEL_W)*W  packed inputs, input i at [i*W +: W]
//   i_sel in  SEL_W         input select
//   i_s_n in  1             strobe, active-low; 1 forces o_y to 0
//   o_y   out W             selected input (or 0)
module mux_slice #(
  parameter int W     = 1,
  parameter int SEL_W = 2
) (
  input  logic [(2**SEL_W)*W-1:0] i_d,
  input  logic [SEL_W-1:0]        i_sel,
  input  logic                    i_s_n,
  output logic [W-1:0]            o_y
);

  always_comb begin
    o_y = '0;
    if (!i_s_n) begin
      o_y = i_d[int'(i_sel)*W +: W];
    end
  end

endmodule

// File: rtl/scan_mux.sv
// scan_mux -- NCH-channel scanning multiplexer with a one-deep registered
// output slot and valid/ready handshake. In manual mode the select comes from
// a_in; in auto mode the select walks 0..NIN-1, dwelling DWELL cycles per
// value, and stalls (without skipping a select) while the slot is occupied.
// Optional feature: define SCAN_MUX_WRAP_EN to add output wrap, a one-cycle
// pulse with each auto capture taken at select NIN-1.
// Ports:
//   clk        in   1             clock, rising edge
//   rst_n      in   1             synchronous reset, active-low
//   d          in   NCH*NIN*W     channel c input i at [(c*NIN+i)*W +: W]
//   s_n        in   NCH           per-channel strobe, active-low
//   mode       in   1             0 manual, 1 auto-scan
//   a_in       in   SEL_W         manual select
//   y          out  NCH*W         registered samples, channel c at [c*W +: W]
//   a_out      out  SEL_W         select that produced y
//   out_valid  out  1             y/a_out hold an unconsumed sample
//   out_ready  in   1             consumer accepts when out_valid && out_ready
//   wrap       out  1             (SCAN_MUX_WRAP_EN only) scan wrap pulse
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int W     = 1,
  parameter int NCH   = 2,
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NCH*(2**SEL_W)*W-1:0]  d,
  input  logic [NCH-1:0]               s_n,
  input  logic                         mode,
  input  logic [SEL_W-1:0]             a_in,
  output logic [NCH*W-1:0]             y,
  output logic [SEL_W-1:0]             a_out,
  output logic                         out_valid,
  input  logic                         out_ready
`ifdef SCAN_MUX_WRAP_EN
  ,
  output logic                         wrap
`endif
);

  localparam int NIN = 2**SEL_W;
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_e           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_scan, w_scan_nxt;
  logic [7:0]       r_dwell, w_dwell_nxt;
  logic [NCH*W-1:0] r_y;
  logic [SEL_W-1:0] r_a_out;
  logic             r_valid;

  logic             w_free;
  logic             w_cap;
  logic             w_auto_cap;
  logic [SEL_W-1:0] w_sel;
  logic [NCH*W-1:0] w_y;

  // The slot can take a new sample when empty or being drained this cycle.
  assign w_free = !r_valid || out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_scan_nxt  = r_scan;
    w_dwell_nxt = r_dwell;
    w_cap       = 1'b0;
    w_auto_cap  = 1'b0;
    w_sel       = a_in;
    case (r_state)
      MANUAL: begin
        w_cap = w_free;
        if (mode == MODE_AUTO) begin
          w_state_nxt = AUTO_DWELL;
          w_scan_nxt  = '0;
          w_dwell_nxt = '0;
        end
      end
      AUTO_DWELL: begin
        if (mode == MODE_MANUAL) begin
          w_state_nxt = MANUAL;
        end else if (r_dwell == DWELL_LAST) begin
          if (w_free) begin
            w_cap       = 1'b1;
            w_auto_cap  = 1'b1;
            w_sel       = r_scan;
            w_scan_nxt  = r_scan + 1'b1;
            w_dwell_nxt = '0;
          end else begin
            // Counters freeze so the pending select is not skipped.
            w_state_nxt = AUTO_HOLD;
          end
        end else begin
          w_dwell_nxt = r_dwell + 8'd1;
        end
      end
      AUTO_HOLD: begin
        if (mode == MODE_MANUAL) begin
          w_state_nxt = MANUAL;
        end else if (w_free) begin
          w_cap       = 1'b1;
          w_auto_cap  = 1'b1;
          w_sel       = r_scan;
          w_scan_nxt  = r_scan + 1'b1;
          w_dwell_nxt = '0;
          w_state_nxt = AUTO_DWELL;
        end
      end
      default: w_state_nxt = MANUAL;
    endcase
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    mux_slice #(
      .W     (W),
      .SEL_W (SEL_W)
    ) u_mux_slice (
      .i_d   (d[c*NIN*W +: NIN*W]),
      .i_sel (w_sel),
      .i_s_n (s_n[c]),
      .o_y   (w_y[c*W +: W])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= MANUAL;
      r_scan  <= '0;
      r_dwell <= '0;
      r_y     <= '0;
      r_a_out <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_scan  <= w_scan_nxt;
      r_dwell <= w_dwell_nxt;
      if (w_cap) begin
        r_y     <= w_y;
        r_a_out <= w_sel;
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef SCAN_MUX_WRAP_EN
  logic r_wrap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_auto_cap && (w_sel == SEL_W'(NIN - 1));
    end
  end

  assign wrap = r_wrap;
`endif

  assign y         = r_y;
  assign a_out     = r_a_out;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux -- self-checking bench for scan_mux. Two instances share the
// stimulus: DWELL = 4 and DWELL = 1. A behavioural model per instance tracks
// the expected outputs; directed literal checks pin specific scenarios.
// Define SCAN_MUX_WRAP_EN to also exercise the wrap output.
module tb_scan_mux;

  localparam int W     = 1;
  localparam int NCH   = 2;
  localparam int SEL_W = 2;
  localparam int NIN   = 4;
  localparam int DW [2] = '{4, 1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d;
  logic [1:0] s_n;
  logic       mode;
  logic [1:0] a_in;
  logic       out_ready;

  logic [1:0] y0, y1, a0, a1;
  logic       vld0, vld1;
`ifdef SCAN_MUX_WRAP_EN
  logic       wrap0, wrap1;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  scan_mux #(.W(W), .NCH(NCH), .SEL_W(SEL_W), .DWELL(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .d(d), .s_n(s_n), .mode(mode), .a_in(a_in),
    .y(y0), .a_out(a0), .out_valid(vld0), .out_ready(out_ready)
`ifdef SCAN_MUX_WRAP_EN
    , .wrap(wrap0)
`endif
  );

  scan_mux #(.W(W), .NCH(NCH), .SEL_W(SEL_W), .DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .d(d), .s_n(s_n), .mode(mode), .a_in(a_in),
    .y(y1), .a_out(a1), .out_valid(vld1), .out_ready(out_ready)
`ifdef SCAN_MUX_WRAP_EN
    , .wrap(wrap1)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] pick(input logic [7:0] dd, input logic [1:0] sn, input int sel);
    logic [1:0] r;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      if (!sn[c]) r[c] = dd[c*NIN + sel];
    end
    return r;
  endfunction

  // Behavioural model: in auto mode a sample becomes due once the dwell age
  // reaches DWELL-1, and stays due until the slot is free.
  bit         m_auto [2];
  int         m_age  [2];
  int         m_next [2];
  bit         m_valid[2];
  bit         m_wrap [2];
  logic [1:0] m_y    [2];
  logic [1:0] m_a    [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_auto[k] = 0; m_age[k] = 0; m_next[k] = 0;
        m_valid[k] = 0; m_wrap[k] = 0; m_y[k] = '0; m_a[k] = '0;
      end else begin
        bit free, cap, acap;
        int sel;
        free = !m_valid[k] || out_ready;
        cap = 0; acap = 0; sel = 0;
        if (!m_auto[k]) begin
          cap = free;
          sel = int'(a_in);
          if (mode) begin
            m_auto[k] = 1; m_age[k] = 0; m_next[k] = 0;
          end
        end else if (!mode) begin
          m_auto[k] = 0;
        end else if (m_age[k] >= DW[k] - 1) begin
          if (free) begin
            cap = 1; acap = 1; sel = m_next[k];
            m_next[k] = (m_next[k] + 1) % NIN;
            m_age[k] = 0;
          end
        end else begin
          m_age[k]++;
        end
        m_wrap[k] = acap && (sel == NIN - 1);
        if (cap) begin
          m_y[k] = pick(d, s_n, sel);
          m_a[k] = 2'(sel);
          m_valid[k] = 1;
        end else if (out_ready) begin
          m_valid[k] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model y0", 32'(y0), 32'(m_y[0]));
      check("model a0", 32'(a0), 32'(m_a[0]));
      check("model vld0", 32'(vld0), 32'(m_valid[0]));
      check("model y1", 32'(y1), 32'(m_y[1]));
      check("model a1", 32'(a1), 32'(m_a[1]));
      check("model vld1", 32'(vld1), 32'(m_valid[1]));
`ifdef SCAN_MUX_WRAP_EN
      check("model wrap0", 32'(wrap0), 32'(m_wrap[0]));
      check("model wrap1", 32'(wrap1), 32'(m_wrap[1]));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int got0[$];
  int got1[$];
  int wraps;

  initial begin
    rst_n = 1'b0; mode = 1'b0; a_in = '0; d = '0; s_n = '0; out_ready = 1'b1;
    step(3);
    chk_en = 1'b1;
    check("reset y0", 32'(y0), 0);
    check("reset vld0", 32'(vld0), 0);
    check("reset a0", 32'(a0), 0);
    check("reset vld1", 32'(vld1), 0);

    // Manual: ch0 = 0100, ch1 = 1011, select 2 -> ch0 = 1, ch1 = 0.
    rst_n = 1'b1; d = 8'b1011_0100; a_in = 2'd2;
    step(1);
    check("manual y", 32'(y0), 32'h1);
    check("manual a_out", 32'(a0), 2);
    check("manual valid", 32'(vld0), 1);
    s_n = 2'b01; step(1);
    check("strobe ch0 y", 32'(y0), 32'h0);
    s_n = 2'b10; step(1);
    check("strobe ch1 y", 32'(y0), 32'h1);
    s_n = 2'b00;

    // Backpressure in manual mode holds the slot.
    out_ready = 1'b0; a_in = 2'd1; step(3);
    check("stall y", 32'(y0), 32'h1);
    check("stall a_out", 32'(a0), 2);
    check("stall valid", 32'(vld0), 1);
    out_ready = 1'b1; step(1);
    check("release y", 32'(y0), 32'h2);
    check("release a_out", 32'(a0), 1);

    // Auto scan.
    mode = 1'b1; a_in = 2'd0;
    step(1);
    wraps = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (vld0) got0.push_back(int'(a0));
      if (vld1 && got1.size() < 6) got1.push_back(int'(a1));
`ifdef SCAN_MUX_WRAP_EN
      if (wrap0) begin
        wraps++;
        check("wrap0 with a_out 3", 32'(a0), 3);
      end
`endif
    end
    check("dwell4 sample count", 32'(got0.size()), 5);
    for (int i = 0; i < 5 && i < got0.size(); i++)
      check("dwell4 a_out seq", 32'(got0[i]), 32'(i % 4));
    check("dwell1 sample count", 32'(got1.size()), 6);
    for (int i = 0; i < 6 && i < got1.size(); i++)
      check("dwell1 a_out seq", 32'(got1[i]), 32'(i % 4));
`ifdef SCAN_MUX_WRAP_EN
    check("wrap0 pulse count", 32'(wraps), 1);
`endif

    // Hold: scan stalls while the slot is full, then resumes at select 1.
    out_ready = 1'b0; step(10);
    check("hold a_out", 32'(a0), 0);
    check("hold y", 32'(y0), 32'h2);
    check("hold valid", 32'(vld0), 1);
    out_ready = 1'b1; step(1);
    check("resume a_out", 32'(a0), 1);
    check("resume valid", 32'(vld0), 1);

    // Reset while holding with the consumer stalled.
    out_ready = 1'b0; step(6);
    rst_n = 1'b0; step(1);
    check("rst hold y", 32'(y0), 0);
    check("rst hold valid", 32'(vld0), 0);
    check("rst hold a_out", 32'(a0), 0);
    // First cycle after reset captures a_in only if the FSM is MANUAL.
    rst_n = 1'b1; a_in = 2'd3; out_ready = 1'b1; step(1);
    check("post-rst manual a_out", 32'(a0), 3);
    check("post-rst manual y", 32'(y0), 32'h2);
    check("post-rst manual valid", 32'(vld0), 1);

    // Mixed traffic checked by the model.
    for (int i = 0; i < 80; i++) begin
      out_ready = 1'($urandom_range(0, 3) != 0);
      if (i % 9 == 0) mode = ~mode;
      d = 8'($urandom);
      s_n = 2'($urandom_range(0, 3) == 0 ? $urandom : 0);
      a_in = 2'($urandom);
      if (i == 50) rst_n = 1'b0;
      if (i == 52) rst_n = 1'b1;
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
